// File: rtl/smpl_tx_sched.sv
// smpl_tx_sched: streams the enabled byte groups of one sample word, lowest group first, to a byte transmitter
module smpl_tx_sched #(
  parameter int SMPL_WIDTH = 32,
  parameter int NUM_GRP = SMPL_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  input  logic [NUM_GRP-1:0]    grp_en_i,
  input  logic                  abort_i,
  input  logic                  stb_i,
  input  logic [SMPL_WIDTH-1:0] smpl_i,
  output logic                  rdy_o,
  input  logic                  tx_rdy_i,
  output logic                  tx_stb_o,
  output logic [7:0]            tx_o,
  output logic                  busy_o
);
  localparam int SW = NUM_GRP > 1 ? $clog2(NUM_GRP) : 1;
  typedef enum logic [1:0] {IDLE, SEND, STB, ACK} state_t;
  state_t                state;
  logic [SMPL_WIDTH-1:0] word_q;
  logic [NUM_GRP-1:0]    pend_q;
  logic [SW-1:0]         sel;
  always_comb begin
    sel = '0;
    for (int i = NUM_GRP - 1; i >= 0; i--)
      if (pend_q[i]) sel = SW'(i);
  end
  assign rdy_o    = state == IDLE;
  assign busy_o   = ~rdy_o;
  assign tx_stb_o = state == STB && !abort_i;
  // ACK waits for the transmitter to drop ready so a stale ready never re-sends
  always_ff @(posedge clk_i)
    if (!rst_in) begin
      state  <= IDLE;
      word_q <= '0;
      pend_q <= '0;
      tx_o   <= '0;
    end else if (abort_i) begin
      state  <= IDLE;
      pend_q <= '0;
    end else
      case (state)
        IDLE: if (stb_i) begin
          word_q <= smpl_i;
          pend_q <= grp_en_i;
          if (|grp_en_i) state <= SEND;
        end
        SEND: if (tx_rdy_i) begin
          tx_o  <= word_q[8*sel +: 8];
          state <= STB;
        end
        STB: begin
          pend_q[sel] <= 1'b0;
          state       <= ACK;
        end
        ACK: if (!tx_rdy_i) state <= |pend_q ? SEND : IDLE;
      endcase
endmodule

// File: tb/tb_smpl_tx_sched.sv
// tb_smpl_tx_sched: byte-queue reference model, per-cycle compare, directed and random stimulus
module tb_smpl_tx_sched;
  logic        clk_i = 0;
  logic        rst_in = 0;
  logic [3:0]  grp_en_i = 0;
  logic        abort_i = 0;
  logic        stb_i = 0;
  logic [31:0] smpl_i = 0;
  logic        rdy_o;
  logic        tx_rdy_i = 1;
  logic        tx_stb_o;
  logic [7:0]  tx_o;
  logic        busy_o;

  smpl_tx_sched #(.SMPL_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .grp_en_i(grp_en_i), .abort_i(abort_i),
    .stb_i(stb_i), .smpl_i(smpl_i), .rdy_o(rdy_o), .tx_rdy_i(tx_rdy_i),
    .tx_stb_o(tx_stb_o), .tx_o(tx_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the word becomes a queue of bytes to send; each byte needs
  // ready high, one strobe cycle, then ready low before the next one.
  typedef enum {P_IDLE, P_WAIT, P_STB, P_DROP} ph_t;
  ph_t        m_ph = P_IDLE;
  logic [7:0] q[$];
  logic [7:0] m_tx = 0;

  always @(posedge clk_i) begin
    cyc++;
    if (!rst_in) begin
      m_ph = P_IDLE;
      q.delete();
      m_tx = 0;
    end else if (abort_i) begin
      m_ph = P_IDLE;
      q.delete();
    end else
      case (m_ph)
        P_IDLE: if (stb_i) begin
          q.delete();
          for (int g = 0; g < 4; g++) if (grp_en_i[g]) q.push_back(smpl_i[8*g +: 8]);
          if (q.size() != 0) m_ph = P_WAIT;
        end
        P_WAIT: if (tx_rdy_i) begin
          m_tx = q[0];
          m_ph = P_STB;
        end
        P_STB: begin
          void'(q.pop_front());
          m_ph = P_DROP;
        end
        P_DROP: if (!tx_rdy_i) m_ph = q.size() != 0 ? P_WAIT : P_IDLE;
      endcase
  end

  logic [7:0] blog[$];
  int         scyc[$];

  always @(negedge clk_i) if (chk_en) begin
    chk("rdy_o", rdy_o, m_ph == P_IDLE);
    chk("busy_o", busy_o, m_ph != P_IDLE);
    chk("tx_stb_o", tx_stb_o, m_ph == P_STB && !abort_i);
    chk("tx_o", tx_o, m_tx);
    if (tx_stb_o === 1'b1) begin
      blog.push_back(tx_o);
      scyc.push_back(cyc);
    end
  end

  // Transmitter responder: after a strobe stays ready for d0 cycles, then busy for lo_n cycles
  int  d0 = 0, lo_n = 3, hold = 0, low = 0;
  bit  armed = 0, rnd = 0;
  always @(negedge clk_i) if (tx_stb_o === 1'b1) begin
    hold  = rnd ? $urandom_range(1, 0) : d0;
    low   = rnd ? $urandom_range(4, 1) : lo_n;
    armed = 1;
  end
  always @(posedge clk_i) begin
    #1;
    if (armed) begin
      if (hold > 0) begin hold--; tx_rdy_i = 1; end
      else if (low > 0) begin low--; tx_rdy_i = 0; end
      else begin tx_rdy_i = 1; armed = 0; end
    end else tx_rdy_i = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic send(input logic [31:0] w, input logic [3:0] m, output int acc);
    for (int i = 0; i < 200 && m_ph != P_IDLE; i++) step();
    stb_i = 1; smpl_i = w; grp_en_i = m;
    acc = cyc;
    step();
    stb_i = 0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 300 && (m_ph != P_IDLE || armed); i++) step();
    checks++;
    if (i == 300) begin
      errors++;
      $display("FAIL wait_done: still busy after 300 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, n;
    step(); step();
    chk_en = 1;
    rst_in = 1;
    chk("reset rdy_o", rdy_o, 1);
    chk("reset busy_o", busy_o, 0);
    chk("reset tx_stb_o", tx_stb_o, 0);
    chk("reset tx_o", tx_o, 0);

    blog.delete(); scyc.delete();
    send(32'hDDCCBBAA, 4'b1111, a0);
    wait_done();
    chk("all count", blog.size(), 4);
    if (blog.size() == 4) begin
      chk("all b0", blog[0], 8'hAA);
      chk("all b1", blog[1], 8'hBB);
      chk("all b2", blog[2], 8'hCC);
      chk("all b3", blog[3], 8'hDD);
      chk("latency", scyc[0] - a0, 2);
    end

    blog.delete(); scyc.delete();
    send(32'h44332211, 4'b1010, a0);
    grp_en_i = 4'b0001;
    wait_done();
    chk("sparse count", blog.size(), 2);
    if (blog.size() == 2) begin
      chk("sparse b0", blog[0], 8'h22);
      chk("sparse b1", blog[1], 8'h44);
    end

    blog.delete(); scyc.delete();
    send(32'hCAFEF00D, 4'b0000, a0);
    chk("zero rdy_o", rdy_o, 1);
    send(32'h12345655, 4'b0001, a1);
    wait_done();
    chk("zero next accept", a1 - a0, 1);
    chk("zero count", blog.size(), 1);
    if (blog.size() == 1) begin
      chk("zero b0", blog[0], 8'h55);
      chk("zero latency", scyc[0] - a0, 3);
    end

    blog.delete(); scyc.delete();
    d0 = 3; lo_n = 1;
    send(32'h0000BEEF, 4'b0011, a0);
    wait_done();
    chk("stale count", blog.size(), 2);
    if (blog.size() == 2) begin
      chk("stale b0", blog[0], 8'hEF);
      chk("stale b1", blog[1], 8'hBE);
      chk("stale gap", scyc[1] - scyc[0], 6);
    end
    d0 = 0; lo_n = 3;

    blog.delete(); scyc.delete();
    send(32'h000000A5, 4'b0001, a0);
    for (int i = 0; i < 50 && m_ph != P_STB; i++) step();
    abort_i = 1; stb_i = 1; smpl_i = 32'h99887766; grp_en_i = 4'b1111;
    #1;
    chk("abort tx_stb_o", tx_stb_o, 0);
    step();
    abort_i = 0; stb_i = 0;
    chk("abort rdy_o", rdy_o, 1);
    repeat (8) step();
    chk("abort count", blog.size(), 0);

    blog.delete(); scyc.delete();
    lo_n = 2;
    send(32'h87654321, 4'b1111, a0);
    for (int i = 0; i < 50 && blog.size() == 0; i++) step();
    rst_in = 0;
    step();
    rst_in = 1;
    chk("rst tx_o", tx_o, 0);
    chk("rst rdy_o", rdy_o, 1);
    chk("rst busy_o", busy_o, 0);
    repeat (12) step();
    chk("rst count", blog.size(), 1);
    if (blog.size() == 1) chk("rst b0", blog[0], 8'h21);
    send(32'hA1B2C3D4, 4'b0101, a0);
    wait_done();
    chk("fresh count", blog.size(), 3);
    if (blog.size() == 3) begin
      chk("fresh b0", blog[1], 8'hD4);
      chk("fresh b1", blog[2], 8'hB2);
    end

    rnd = 1;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      stb_i    = $urandom_range(1, 0);
      smpl_i   = $urandom;
      grp_en_i = 4'($urandom);
      abort_i  = $urandom_range(39, 0) == 0;
      if (i == 1500) rst_in = 0;
      else rst_in = 1;
      step();
    end
    stb_i = 0; abort_i = 0; rst_in = 1;
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/smpl_tx_sched.md
Name: smpl_tx_sched

Overview:
- Sequences one captured sample word into the byte-wide transmitter, one enabled channel group at a time.
- Sits between the capture controller's memory read-out (sample word + strobe) and the UART transmitter.
- Honours the per-group channel-disable mask so that only enabled 8-bit groups are sent, lowest group first.
- Provides flow control back to the controller so the next word is requested only when the current one is fully sent.

Parameters:
- SMPL_WIDTH, 32, bits of one sample word; must be a multiple of 8.
- NUM_GRP, SMPL_WIDTH/8, number of 8-bit channel groups (derived; do not override).

Ports:
- clk_i  in  1  system clock
- rst_in  in  1  synchronous reset, active low
- grp_en_i  in  NUM_GRP  group enable mask, bit g=1 sends smpl_i[8g+7:8g]
- abort_i  in  1  drop current word and return to IDLE
- stb_i  in  1  sample word valid
- smpl_i  in  SMPL_WIDTH  sample word
- rdy_o  out  1  ready to accept a word
- tx_rdy_i  in  1  transmitter idle
- tx_stb_o  out  1  one-cycle transmit strobe
- tx_o  out  8  byte to transmit
- busy_o  out  1  word in flight

Behaviour:
- Clocking and reset: single clock domain. All state updates on posedge clk_i. rst_in low at an edge forces:
  - state=IDLE
  - word register=0, pending mask=0, tx_o=0
  - hence rdy_o=1, busy_o=0, tx_stb_o=0
- Reset mid-operation discards the word; no further strobe is issued.
- Registers:
  - word_q[SMPL_WIDTH]: captured sample word.
  - pend_q[NUM_GRP]: groups still to send.
  - sel: combinational index of the lowest set bit of pend_q.
  - tx_o is registered and loaded with word_q[8*sel+7:8*sel] on entry to STB.
- States: IDLE, SEND, STB, ACK.
- IDLE (rdy_o=1, busy_o=0):
  - If stb_i=1: latch word_q=smpl_i and pend_q=grp_en_i.
  - Go to SEND if grp_en_i is nonzero.
  - If grp_en_i is zero, the word is consumed silently and the block stays in IDLE.
- SEND (rdy_o=0, busy_o=1): wait for tx_rdy_i=1, then load tx_o and go to STB.
- STB:
  - tx_stb_o=1 for exactly one cycle; tx_o holds a stable byte.
  - Clear pend_q[sel]; go to ACK.
- ACK: wait for tx_rdy_i=0. Then go to IDLE if pend_q is zero, else to SEND.
  - This guards against double-sending on a stale ready.
- Transmitter contract: tx_rdy_i falls within 2 cycles after tx_stb_o and stays low for at least 1 cycle. tx_rdy_i high in ACK is simply waited out.
- Latency: word accepted in cycle 0 with tx_rdy_i held high → tx_stb_o=1 in cycle 2. Per byte: 2 cycles plus transmitter busy time plus 1.
- Mask timing: grp_en_i is sampled only at acceptance. Later changes do not affect a word in flight.
- stb_i outside IDLE is ignored; the upstream block must hold stb_i until it sees rdy_o=1.
- abort_i has priority over all other inputs in every state:
  - Next state is IDLE and pend_q is cleared.
  - tx_stb_o is gated off in the abort cycle (tx_stb_o = (state==STB) & ~abort_i).
  - stb_i is ignored in the same cycle, even in IDLE.
- rdy_o = (state==IDLE); busy_o = ~rdy_o.
- Byte order: ascending group index (group 0 first), matching the host's little-endian expectation.

Test Plan:
- Reset then all groups enabled:
  - Stimulus: grp_en_i=4'b1111, smpl_i=32'hDDCCBBAA, tx_rdy_i modelled as a 3-cycle busy transmitter.
  - Response: tx_o sequence AA,BB,CC,DD with exactly 4 tx_stb_o pulses; rdy_o returns to 1 one cycle after the final ACK.
- Sparse mask:
  - Stimulus: grp_en_i=4'b1010, smpl_i=32'h44332211.
  - Response: bytes 22 then 44 only; grp_en_i changed to 4'b0001 mid-word has no effect.
- Zero mask:
  - Stimulus: grp_en_i=0, stb_i pulse.
  - Response: no tx_stb_o, rdy_o stays 1, and the next word is accepted on the following cycle.
- Stale ready:
  - Stimulus: tx_rdy_i held at 1 for 3 cycles after the strobe.
  - Response: no second strobe until tx_rdy_i has gone 0 and then 1; no byte is duplicated.
- Abort in STB:
  - Stimulus: abort_i=1 while in STB with stb_i=1.
  - Response: tx_stb_o=0 in that cycle, IDLE next cycle, the new word is not accepted; rdy_o=1.
- Reset mid-word:
  - Stimulus: rst_in=0 for 1 cycle after the first byte of 32'h87654321.
  - Response: tx_o=0, rdy_o=1, no further strobes; a fresh word then sends normally.
